// File: rtl/cond_flag_unit_pkg.sv
// rtl/cond_flag_unit_pkg.sv - condition codes, NZCV bit positions and FlagW group meanings
package cond_flag_unit_pkg;

  // Architectural condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_code_t;

  // Bit positions inside the {N,Z,C,V} nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bits as driven by the ALU decoder
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  // Merge freshly produced ALU flags into the current flags, group by group
  function automatic logic [3:0] merge_flags(
    input logic [3:0] cur,
    input logic [3:0] alu,
    input logic [1:0] flag_w
  );
    logic [3:0] res;
    res = cur;
    if (flag_w[FLAGW_NZ]) begin
      res[FLAG_N] = alu[FLAG_N];
      res[FLAG_Z] = alu[FLAG_Z];
    end
    if (flag_w[FLAGW_CV]) begin
      res[FLAG_C] = alu[FLAG_C];
      res[FLAG_V] = alu[FLAG_V];
    end
    return res;
  endfunction

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// rtl/cond_flag_unit_cond_check.sv - combinational condition-field predicate against NZCV
module cond_check
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic base;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Codes come in true/inverted pairs: evaluate the even member, flip on cond[0]; 0xE/0xF always pass
  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'd7) begin
      pass = 1'b1;
    end else begin
      pass = base ^ cond[0];
    end
  end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - E-stage NZCV register, condition gating and branch resolve; COND_PERF_CNT_EN adds branch/mispredict counters
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [3:0]       cond_e,
  input  logic [1:0]       flag_w_e,
  input  logic [3:0]       alu_flags_e,
  input  logic             pcs_e,
  input  logic             reg_w_e,
  input  logic             mem_w_e,
  input  logic             branch_e,
  input  logic             pred_taken_e,
  output logic [3:0]       flags_q,
  output logic             cond_ex_e,
  output logic             pcs_g,
  output logic             reg_w_g,
  output logic             mem_w_g,
  output logic             branch_taken_e,
  output logic             mispredict_e,
`ifdef COND_PERF_CNT_EN
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt,
`endif
  output logic             redirect_q
);

  logic alive;
  logic live;
  logic flag_upd;

  // Predicate sees only flags written by older instructions (no bypass of alu_flags_e)
  cond_check u_cond_check (
    .cond  (cond_e),
    .flags (flags_q),
    .pass  (cond_ex_e)
  );

  assign alive = valid_e & ~flush_e;
  assign live  = alive & cond_ex_e;

  // Side-effect gating and branch resolution
  always_comb begin
    pcs_g          = pcs_e & live;
    reg_w_g        = reg_w_e & live;
    mem_w_g        = mem_w_e & live;
    branch_taken_e = branch_e & live;
    mispredict_e   = alive & branch_e & (branch_taken_e != pred_taken_e);
  end

  assign flag_upd = live & ~stall_e;

  // Architectural flag register; each FlagW group loads independently
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RST;
    end else if (flag_upd) begin
      flags_q <= merge_flags(flags_q, alu_flags_e, flag_w_e);
    end
  end

  // One-cycle redirect to fetch; held off while stalled so the mispredict re-presents on release
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= mispredict_e & ~stall_e;
    end
  end

`ifdef COND_PERF_CNT_EN
  logic br_inc;
  logic mis_inc;

  assign br_inc  = alive & branch_e & ~stall_e;
  assign mis_inc = mispredict_e & ~stall_e;

  // Saturating branch and mispredict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (br_inc && (br_cnt != {CNT_W{1'b1}})) begin
        br_cnt <= br_cnt + 1'b1;
      end
      if (mis_inc && (mis_cnt != {CNT_W{1'b1}})) begin
        mis_cnt <= mis_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
